// File: rtl/fwd_hazard_tracker_pkg.sv
// Shared definitions for the forwarding/stall tracker: tracker entry layout,
// the register-file select encoding and select-width helpers.
package fwd_hazard_tracker_pkg;

    // Entry layout: flags in the low bits, destination register above them.
    localparam int unsigned E_VALID = 0;
    localparam int unsigned E_WREN  = 1;
    localparam int unsigned E_LOAD  = 2;
    localparam int unsigned E_DST   = 3;
    localparam int unsigned E_FLAGS = 3;

    // fwd_sel value meaning "read the register file, no bypass".
    localparam int unsigned FWD_RF = 0;

    function automatic int unsigned sel_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned entry_width(input int unsigned aw);
        return aw + E_FLAGS;
    endfunction

endpackage

// File: rtl/fwd_hazard_tracker_src_match.sv
// Per-operand lookup: finds the youngest in-flight producer of one source
// register and flags a load that is still too close to forward from.
module fwd_src_match
    import fwd_hazard_tracker_pkg::*;
#(
    parameter int AW        = 5,
    parameter int DEPTH     = 3,
    parameter int LOAD_DIST = 2,
    parameter int SELW      = sel_width(DEPTH)
) (
    input  logic                                 id_valid_i,
    input  logic                                 src_used_i,
    input  logic [AW-1:0]                        src_i,
    input  logic [DEPTH*entry_width(AW)-1:0]     tracker_i,
    output logic [SELW-1:0]                      sel_o,
    output logic                                 load_hazard_o
);

    localparam int EW = entry_width(AW);

    logic [DEPTH-1:0] hit;
    logic [DEPTH-1:0] is_load;
    logic             reads_reg;

    assign reads_reg = id_valid_i & src_used_i & (src_i != '0);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        assign hit[gi] = reads_reg
                       & tracker_i[gi*EW + E_VALID]
                       & tracker_i[gi*EW + E_WREN]
                       & (tracker_i[gi*EW + E_DST +: AW] == src_i);
        assign is_load[gi] = tracker_i[gi*EW + E_LOAD];
    end

    // Scan oldest to youngest so the nearest producer overrides older ones.
    always_comb begin
        sel_o         = SELW'(FWD_RF);
        load_hazard_o = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (hit[k-1]) begin
                sel_o         = SELW'(k);
                load_hazard_o = is_load[k-1] && (k < LOAD_DIST);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_tracker.sv
// Forwarding/stall control: tracks the last DEPTH issued instructions and
// returns per-operand bypass distances, load-use stalls and a stall counter.
module fwd_hazard_tracker
    import fwd_hazard_tracker_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int AW        = 5,
    parameter int DEPTH     = 3,
    parameter int LOAD_DIST = 2,
    parameter int CW        = 16,
    localparam int SELW     = sel_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    flush,
    input  logic                    id_valid,
    input  logic [NUM_SRC*AW-1:0]   id_src,
    input  logic [NUM_SRC-1:0]      id_src_used,
    input  logic [AW-1:0]           id_dst,
    input  logic                    id_wren,
    input  logic                    id_load,
    output logic [NUM_SRC*SELW-1:0] fwd_sel,
    output logic                    stall,
    output logic [CW-1:0]           stall_count
);

    localparam int EW = entry_width(AW);

    logic [DEPTH*EW-1:0] tracker_q, tracker_d;
    logic [CW-1:0]       stall_count_q, stall_count_d;
    logic [NUM_SRC-1:0]  hazard;
    logic [EW-1:0]       new_entry;
    logic                issue;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        fwd_src_match #(
            .AW        (AW),
            .DEPTH     (DEPTH),
            .LOAD_DIST (LOAD_DIST),
            .SELW      (SELW)
        ) u_match (
            .id_valid_i    (id_valid),
            .src_used_i    (id_src_used[gi]),
            .src_i         (id_src[gi*AW +: AW]),
            .tracker_i     (tracker_q),
            .sel_o         (fwd_sel[gi*SELW +: SELW]),
            .load_hazard_o (hazard[gi])
        );
    end

    // Flush overrides a hazard: the squashed instruction needs no bubble.
    assign stall = (|hazard) & ~flush;
    assign issue = id_valid & ~stall & ~flush;

    always_comb begin
        new_entry = '0;
        if (issue) begin
            new_entry[E_VALID]     = 1'b1;
            new_entry[E_WREN]      = id_wren;
            new_entry[E_LOAD]      = id_load;
            new_entry[E_DST +: AW] = id_dst;
        end
    end

    always_comb begin
        tracker_d     = tracker_q;
        stall_count_d = stall_count_q;
        if (en) begin
            tracker_d[0 +: EW] = new_entry;
            for (int k = 1; k < DEPTH; k++) begin
                tracker_d[k*EW +: EW] = tracker_q[(k-1)*EW +: EW];
            end
            if (stall && (stall_count_q != '1)) begin
                stall_count_d = stall_count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tracker_q     <= '0;
            stall_count_q <= '0;
        end else begin
            tracker_q     <= tracker_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: doc/fwd_hazard_tracker.md
Name: fwd_hazard_tracker

Overview:
- Parametrised successor to the pipeline forwarding/stall control.
- Keeps its own shift register of in-flight destination tags: the last DEPTH issued instructions with their wren and load flags.
- For each of NUM_SRC source operands of the instruction in decode, it returns the distance to the youngest in-flight producer. The datapath maps that distance to a bypass mux input.
- Raises a load-use stall, inserts bubbles, honours flush and a global pipeline freeze, and counts stall cycles.

Parameters:
- NUM_SRC, 2, number of source operands checked per instruction.
- AW, 5, register-address width. Register 0 is hard-wired zero and is never forwarded.
- DEPTH, 3, number of older instructions tracked. Forward distances run 1..DEPTH.
- LOAD_DIST, 2, minimum distance at which load data can be forwarded. Legal range 1..DEPTH+1.
- CW, 16, stall-counter width.
- Derived localparam SELW = clog2(DEPTH+1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  pipeline advance. 0 freezes all state.
- flush  in  1  squash the instruction currently in decode.
- id_valid  in  1  decode slot holds a real instruction.
- id_src  in  NUM_SRC*AW  source register numbers, operand i at [i*AW +: AW].
- id_src_used  in  NUM_SRC  operand i is actually read.
- id_dst  in  AW  destination register.
- id_wren  in  1  instruction writes id_dst.
- id_load  in  1  instruction is a load (result comes from memory).
- fwd_sel  out  NUM_SRC*SELW  per operand: 0 = register file, k = forward from producer k instructions older.
- stall  out  1  hold decode/fetch and insert a bubble.
- stall_count  out  CW  saturating count of stall cycles.

Behaviour:
- Tracker entry[k], k=1..DEPTH, holds {valid, wren, load, dst}. entry[1] is the instruction issued one cycle ago.
- Reset (async, rst_n=0):
  - every entry valid=0 and wren=0;
  - stall_count=0;
  - so fwd_sel=0 and stall=0.
- Match for operand i at distance k: id_valid & id_src_used[i] & (id_src_i != 0) & entry[k].valid & entry[k].wren & (entry[k].dst == id_src_i).
- fwd_sel_i is the smallest matching k (youngest producer wins), else 0. It is combinational from the id_* inputs and the tracker, with zero latency.
- load_hazard_i = the winning entry is a load and k < LOAD_DIST. Only the youngest match counts; an older load shadowed by a younger ALU write never stalls.
- stall = OR over i of load_hazard_i, masked by !flush. fwd_sel is still driven during a stall.
- Advance on a rising edge with en=1:
  - entry[k] <= entry[k-1] for k=2..DEPTH;
  - entry[1] <= {1, id_wren, id_load, id_dst} if id_valid & !stall & !flush, otherwise a bubble (valid=0);
  - entry[DEPTH] falls off the end.
- A stall repeats with a larger distance each cycle. Load at distance 1 with LOAD_DIST=2 gives exactly one stall cycle; the next cycle returns fwd_sel=2.
- en=0: tracker and stall_count hold. Combinational outputs still reflect the current inputs.
- stall_count increments on each edge where en & stall, saturating at all-ones.
- flush and a hazard in the same cycle: flush wins. stall=0, a bubble is inserted, and no count is added.
- Reset mid-stall: all entries are cleared immediately and stall drops asynchronously.
- Producer with wren=0 or dst=0 never matches.
- Two operands reading the same register get identical fwd_sel.

Decomposition:
- Shared package holds:
  - the entry struct/field offsets (VALID, WREN, LOAD, DST);
  - the FWD_RF=0 encoding;
  - SELW computation.
- One natural sub-module: fwd_src_match. It takes one operand plus the flattened tracker and returns {sel, load_hazard}, with a priority encoder from distance 1 upward. It is instantiated NUM_SRC times via generate.

Test Plan:
- Reset, then with defaults issue ADD r3 and next cycle SUB using src0=r3 → fwd_sel0=1, stall=0. One cycle later a reader of r3 gets fwd_sel=2, then 3, then 0.
- LW r5 then an immediate reader of r5 on src1 → stall=1 for one cycle with fwd_sel1=1. Next cycle stall=0 and fwd_sel1=2. stall_count=1.
- ADD r4 (dist 2) and LW r4 (dist 1) in flight, reader of r4 → youngest wins: fwd_sel=1, stall=1. Swap the order (LW older) → fwd_sel=1, stall=0.
- Source r0 with a producer writing r0, and a producer with wren=0 writing r7 → fwd_sel=0 for both.
- Load-use hazard with flush=1 → stall=0, bubble inserted, count unchanged. en=0 for 3 cycles during a stall → entries and stall_count frozen.
- Drive CW=2 with continuous load-use stalls → stall_count saturates at 3. Assert rst_n=0 mid-stall → stall=0 and stall_count=0 with no clock edge.
